// File: rtl/opp_packet_decoder.sv
// rtl/opp_packet_decoder.sv - opponent packet validator, state holder, reset confirm and link watchdog
//
// Two-stage pipeline in the eth_refclk domain:
//   stage 1 registers the 44-bit word from the receive block,
//   stage 2 range/reserved-checks it and updates the held opponent state.
//
// Ports:
//   clk_in      eth_refclk
//   rst_n       synchronous active-low reset
//   axiiv       word-valid strobe, one cycle per word
//   axiid       received word {x, r, y, r, dir, rrr, game, r, flag, rrr}
//   opp_valid   one-cycle strobe, held fields just updated
//   opp_x/y     last good coordinates
//   opp_dir     last good direction
//   opp_game    last good game status
//   opp_rst_out one-cycle confirmed remote-reset pulse
//   link_alive  high while good packets keep arriving
//   good_cnt    saturating accepted-packet count
//   bad_cnt     saturating rejected-packet count
module opp_packet_decoder #(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int RST_CONFIRM    = 3,
    parameter int X_MAX          = 1023,
    parameter int Y_MAX          = 767,
    parameter int DIR_MAX        = 359,
    parameter int GAME_MAX       = 4
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        axiiv,
    input  logic [43:0] axiid,
    output logic        opp_valid,
    output logic [10:0] opp_x,
    output logic [10:0] opp_y,
    output logic [8:0]  opp_dir,
    output logic [2:0]  opp_game,
    output logic        opp_rst_out,
    output logic        link_alive,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int RC = (RST_CONFIRM < 3) ? 2 : $clog2(RST_CONFIRM + 1);

    // stage 1
    logic        s1_v_q;
    logic [43:0] s1_word_q;

    // stage 2 state
    logic          valid_q,    valid_d;
    logic [10:0]   x_q,        x_d;
    logic [10:0]   y_q,        y_d;
    logic [8:0]    dir_q,      dir_d;
    logic [2:0]    game_q,     game_d;
    logic          rst_out_q,  rst_out_d;
    logic          alive_q,    alive_d;
    logic [15:0]   good_q,     good_d;
    logic [15:0]   bad_q,      bad_d;
    logic [RC-1:0] confirm_q,  confirm_d;
    logic [TW-1:0] timeout_q,  timeout_d;

    // field decode of the registered word
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [8:0]  w_dir;
    logic [2:0]  w_game;
    logic        w_flag;
    logic        w_rsvd_ok;
    logic        w_range_ok;
    logic        w_good;
    logic        w_bad;
    logic [RC-1:0] confirm_inc;

    assign w_x    = s1_word_q[43:33];
    assign w_y    = s1_word_q[31:21];
    assign w_dir  = s1_word_q[19:11];
    assign w_game = s1_word_q[7:5];
    assign w_flag = s1_word_q[3];

    assign w_rsvd_ok  = ~s1_word_q[32] & ~s1_word_q[20] & (s1_word_q[10:8] == 3'd0)
                      & ~s1_word_q[4] & (s1_word_q[2:0] == 3'd0);
    assign w_range_ok = (int'(w_x) <= X_MAX) && (int'(w_y) <= Y_MAX)
                     && (int'(w_dir) <= DIR_MAX) && (int'(w_game) <= GAME_MAX);
    assign w_good     = s1_v_q & w_rsvd_ok & w_range_ok;
    assign w_bad      = s1_v_q & ~(w_rsvd_ok & w_range_ok);
    assign confirm_inc = confirm_q + RC'(1);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_word_q <= '0;
        end else begin
            s1_v_q    <= axiiv;
            if (axiiv) begin
                s1_word_q <= axiid;
            end
        end
    end

    always_comb begin
        valid_d   = 1'b0;
        rst_out_d = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        game_d    = game_q;
        alive_d   = alive_q;
        good_d    = good_q;
        bad_d     = bad_q;
        confirm_d = confirm_q;
        timeout_d = timeout_q;

        // watchdog runs down on its own; a good word below overrides the reload
        if (timeout_q != '0) begin
            timeout_d = timeout_q - TW'(1);
            if (timeout_q == TW'(1)) begin
                alive_d = 1'b0;
            end
        end

        if (w_good) begin
            valid_d   = 1'b1;
            x_d       = w_x;
            y_d       = w_y;
            dir_d     = w_dir;
            game_d    = w_game;
            alive_d   = 1'b1;
            timeout_d = TW'(TIMEOUT_CYCLES);
            if (good_q != 16'hFFFF) begin
                good_d = good_q + 16'd1;
            end
            // a remote reset is only honoured after an unbroken run of flagged good words
            if (w_flag) begin
                if (confirm_inc == RC'(RST_CONFIRM)) begin
                    rst_out_d = 1'b1;
                    confirm_d = '0;
                end else begin
                    confirm_d = confirm_inc;
                end
            end else begin
                confirm_d = '0;
            end
        end else if (w_bad) begin
            confirm_d = '0;
            if (bad_q != 16'hFFFF) begin
                bad_d = bad_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            dir_q     <= '0;
            game_q    <= '0;
            rst_out_q <= 1'b0;
            alive_q   <= 1'b0;
            good_q    <= '0;
            bad_q     <= '0;
            confirm_q <= '0;
            timeout_q <= '0;
        end else begin
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            game_q    <= game_d;
            rst_out_q <= rst_out_d;
            alive_q   <= alive_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            confirm_q <= confirm_d;
            timeout_q <= timeout_d;
        end
    end

    assign opp_valid   = valid_q;
    assign opp_x       = x_q;
    assign opp_y       = y_q;
    assign opp_dir     = dir_q;
    assign opp_game    = game_q;
    assign opp_rst_out = rst_out_q;
    assign link_alive  = alive_q;
    assign good_cnt    = good_q;
    assign bad_cnt     = bad_q;

endmodule

// File: tb/tb_opp_packet_decoder.sv
// tb/tb_opp_packet_decoder.sv - directed self-checking bench for opp_packet_decoder
module tb_opp_packet_decoder;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        axiiv;
    logic [43:0] axiid;
    logic        opp_valid;
    logic [10:0] opp_x;
    logic [10:0] opp_y;
    logic [8:0]  opp_dir;
    logic [2:0]  opp_game;
    logic        opp_rst_out;
    logic        link_alive;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    int n_checks = 0;
    int n_errors = 0;

    opp_packet_decoder #(
        .TIMEOUT_CYCLES (10),
        .RST_CONFIRM    (3),
        .X_MAX          (1023),
        .Y_MAX          (767),
        .DIR_MAX        (359),
        .GAME_MAX       (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .axiiv       (axiiv),
        .axiid       (axiid),
        .opp_valid   (opp_valid),
        .opp_x       (opp_x),
        .opp_y       (opp_y),
        .opp_dir     (opp_dir),
        .opp_game    (opp_game),
        .opp_rst_out (opp_rst_out),
        .link_alive  (link_alive),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
    );

    always #10 clk_in = ~clk_in;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                       input int game, input logic flag);
        logic [10:0] fx;
        logic [10:0] fy;
        logic [8:0]  fd;
        logic [2:0]  fg;
        fx = x[10:0];
        fy = y[10:0];
        fd = dir[8:0];
        fg = game[2:0];
        return {fx, 1'b0, fy, 1'b0, fd, 3'b000, fg, 1'b0, flag, 3'b000};
    endfunction

    // drive one word, then sample at the cycle its result must appear
    task automatic send(input logic [43:0] w, input logic ev, input logic er, input string tag);
        @(negedge clk_in);
        axiiv = 1'b1;
        axiid = w;
        @(negedge clk_in);
        axiiv = 1'b0;
        check({tag, "_early"}, opp_valid, 1'b0);
        @(negedge clk_in);
        check({tag, "_valid"}, opp_valid, ev);
        check({tag, "_rst"}, opp_rst_out, er);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        axiiv = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, opp_valid, 1'b0);
        check({tag, "_x"},     opp_x, 11'd0);
        check({tag, "_y"},     opp_y, 11'd0);
        check({tag, "_dir"},   opp_dir, 9'd0);
        check({tag, "_game"},  opp_game, 3'd0);
        check({tag, "_rst"},   opp_rst_out, 1'b0);
        check({tag, "_alive"}, link_alive, 1'b0);
        check({tag, "_good"},  good_cnt, 16'd0);
        check({tag, "_bad"},   bad_cnt, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        axiiv = 1'b0;
        axiid = '0;
        do_reset();
        @(negedge clk_in);
        check_all_zero("reset");

        // single good word
        send(mk(100, 200, 90, 1, 1'b0), 1'b1, 1'b0, "w1");
        check("w1_x", opp_x, 11'd100);
        check("w1_y", opp_y, 11'd200);
        check("w1_dir", opp_dir, 9'd90);
        check("w1_game", opp_game, 3'd1);
        check("w1_good", good_cnt, 16'd1);
        check("w1_alive", link_alive, 1'b1);
        @(negedge clk_in);
        check("w1_pulse_end", opp_valid, 1'b0);

        // rejected words leave the held state alone
        send(mk(5, 5, 360, 0, 1'b0), 1'b0, 1'b0, "bad_dir");
        send(mk(5, 768, 5, 0, 1'b0), 1'b0, 1'b0, "bad_y");
        send(mk(5, 5, 5, 0, 1'b0) | (44'd1 << 32), 1'b0, 1'b0, "bad_r32");
        check("bad_x", opp_x, 11'd100);
        check("bad_y_hold", opp_y, 11'd200);
        check("bad_dir_hold", opp_dir, 9'd90);
        check("bad_cnt3", bad_cnt, 16'd3);
        check("bad_good", good_cnt, 16'd1);
        send(mk(1024, 5, 5, 0, 1'b0), 1'b0, 1'b0, "bad_x1024");
        send(mk(5, 5, 5, 5, 1'b0), 1'b0, 1'b0, "bad_game5");
        send(mk(5, 5, 5, 0, 1'b0) | 44'd1, 1'b0, 1'b0, "bad_r0");
        check("bad_cnt6", bad_cnt, 16'd6);

        // largest legal values are accepted
        send(mk(1023, 767, 359, 4, 1'b0), 1'b1, 1'b0, "edge");
        check("edge_x", opp_x, 11'd1023);
        check("edge_y", opp_y, 11'd767);
        check("edge_dir", opp_dir, 9'd359);
        check("edge_game", opp_game, 3'd4);
        check("edge_good", good_cnt, 16'd2);

        // reset confirm: three flagged words fire on the third
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_a1");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_a2");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b1, "rf_a3");
        @(negedge clk_in);
        check("rf_a3_end", opp_rst_out, 1'b0);
        // 1,1,0,1,1 never fires
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_b1");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_b2");
        send(mk(1, 1, 1, 0, 1'b0), 1'b1, 1'b0, "rf_b3");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_b4");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_b5");
        send(mk(1, 1, 1, 0, 1'b0), 1'b1, 1'b0, "rf_clr");
        // 1,1,bad,1,1,1 fires only on the last
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_c1");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_c2");
        send(mk(1, 1, 400, 0, 1'b1), 1'b0, 1'b0, "rf_c3");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_c4");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b0, "rf_c5");
        send(mk(1, 1, 1, 0, 1'b1), 1'b1, 1'b1, "rf_c6");

        // link timeout, 10 cycles after the opp_valid edge
        send(mk(77, 66, 55, 2, 1'b0), 1'b1, 1'b0, "to_w");
        check("to_alive0", link_alive, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_in);
            check($sformatf("to_alive%0d", k), link_alive, 1'b1);
        end
        @(negedge clk_in);
        check("to_drop", link_alive, 1'b0);
        check("to_hold_x", opp_x, 11'd77);
        check("to_hold_y", opp_y, 11'd66);
        check("to_hold_dir", opp_dir, 9'd55);
        check("to_hold_game", opp_game, 3'd2);
        repeat (3) @(negedge clk_in);
        check("to_stay_down", link_alive, 1'b0);
        send(mk(8, 8, 8, 0, 1'b0), 1'b1, 1'b0, "to_back");
        check("to_back_alive", link_alive, 1'b1);

        // back-to-back stream from a clean start
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk_in);
            if (i >= 2) begin
                check($sformatf("b2b_v%0d", i - 2), opp_valid, 1'b1);
                check($sformatf("b2b_x%0d", i - 2), opp_x, 11'(i - 2));
            end else begin
                check($sformatf("b2b_pre%0d", i), opp_valid, 1'b0);
            end
            if (i < 20) begin
                axiiv = 1'b1;
                axiid = mk(i, 3, 4, 0, 1'b0);
            end else begin
                axiiv = 1'b0;
            end
        end
        @(negedge clk_in);
        check("b2b_done", opp_valid, 1'b0);
        check("b2b_good", good_cnt, 16'd20);

        // reset coincident with a word mid-stream
        @(negedge clk_in);
        axiiv = 1'b1;
        axiid = mk(50, 50, 50, 1, 1'b0);
        @(negedge clk_in);
        axiid = mk(51, 50, 50, 1, 1'b0);
        @(negedge clk_in);
        axiid = mk(52, 50, 50, 1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
        axiiv = 1'b0;
        check_all_zero("midrst");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            check($sformatf("midrst_nov%0d", k), opp_valid, 1'b0);
        end
        check("midrst_good", good_cnt, 16'd0);

        // drive good_cnt to saturation with a long stream
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk_in);
            axiiv = 1'b1;
            axiid = mk(i % 1024, 1, 1, 0, 1'b0);
        end
        @(negedge clk_in);
        axiiv = 1'b0;
        @(negedge clk_in);
        check("sat_full", good_cnt, 16'hFFFF);
        send(mk(9, 9, 9, 3, 1'b0), 1'b1, 1'b0, "sat_w");
        check("sat_hold", good_cnt, 16'hFFFF);
        check("sat_x", opp_x, 11'd9);
        check("sat_bad", bad_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
